// File: rtl/adc_ctrl_serial.sv
// adc_ctrl_serial
// Turns the 32-bit software control word into a 19-bit frame on the ADC's
// 3-wire configuration port. A frame is sent only when bit 31 of the word
// toggles, so writing the same word again does not send it again.
//
// Ports
//   user_clk    in   block clock, rising edge
//   user_rst    in   asynchronous active-high reset
//   ctrl_word   in   [31] launch toggle, [18:16] ADC address, [15:0] data
//   adc_sclk    out  serial clock; the ADC samples on the rising edge
//   adc_sdata   out  serial data, MSB first
//   adc_sle_n   out  serial load enable, active low
//   busy        out  high from the SLE_n fall to the end of GAP
//   status_out  out  {busy, 15'b0, xfer_count[15:0]}
//
// state | meaning
// ARM   | first cycle after reset; takes the current toggle as already sent
// IDLE  | port idle, waiting for bit 31 to differ from last_tog
// SETUP | SLE_n low, SCLK low, first bit held on SDATA
// SHIFT | 19 SCLK periods; the next bit goes onto SDATA on each falling edge
// HOLD  | SCLK low, SLE_n still low after the last bit
// GAP   | SLE_n high, busy still set, before the port is free again
module adc_ctrl_serial #(
    parameter int unsigned CLK_DIV = 8
) (
    input  logic        user_clk,
    input  logic        user_rst,
    input  logic [31:0] ctrl_word,
    output logic        adc_sclk,
    output logic        adc_sdata,
    output logic        adc_sle_n,
    output logic        busy,
    output logic [31:0] status_out
);

    typedef enum logic [2:0] {ARM, IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

    localparam logic [7:0] PHASE_LOAD = 8'(CLK_DIV - 1);
    localparam logic [4:0] LAST_BIT   = 5'd18;

    state_t      state_q;
    logic [31:0] cw_q;
    logic        last_tog_q;
    logic [18:0] shift_q;
    logic [7:0]  phase_q;
    logic [4:0]  bit_q;
    logic        sclk_q;
    logic        sdata_q;
    logic        sle_n_q;
    logic        busy_q;
    logic [15:0] xfer_count_q;
    logic [15:0] xfer_count_d;
    logic        launch_req;
    logic [18:0] frame;
    logic        unused_cw;

    assign launch_req   = (cw_q[31] != last_tog_q);
    assign frame        = {cw_q[18:16], cw_q[15:0]};
    assign xfer_count_d = xfer_count_q + 16'd1;
    assign unused_cw    = ^cw_q[30:19];

    always_ff @(posedge user_clk or posedge user_rst) begin
        if (user_rst) begin
            cw_q <= '0;
        end else begin
            cw_q <= ctrl_word;
        end
    end

    always_ff @(posedge user_clk or posedge user_rst) begin
        if (user_rst) begin
            state_q      <= ARM;
            last_tog_q   <= 1'b0;
            shift_q      <= '0;
            phase_q      <= '0;
            bit_q        <= '0;
            sclk_q       <= 1'b0;
            sdata_q      <= 1'b0;
            sle_n_q      <= 1'b1;
            busy_q       <= 1'b0;
            xfer_count_q <= '0;
        end else begin
            unique case (state_q)
                ARM: begin
                    // cw_q still holds its reset value on this edge, so the
                    // toggle is taken from the word being registered right now.
                    // A word left set across reset is then never re-sent.
                    last_tog_q <= ctrl_word[31];
                    state_q    <= IDLE;
                end
                IDLE: begin
                    if (launch_req) begin
                        shift_q    <= frame;
                        last_tog_q <= cw_q[31];
                        sle_n_q    <= 1'b0;
                        sdata_q    <= frame[18];
                        busy_q     <= 1'b1;
                        phase_q    <= PHASE_LOAD;
                        state_q    <= SETUP;
                    end
                end
                SETUP: begin
                    if (phase_q == 8'd0) begin
                        sclk_q  <= 1'b1;
                        bit_q   <= 5'd0;
                        phase_q <= PHASE_LOAD;
                        state_q <= SHIFT;
                    end else begin
                        phase_q <= phase_q - 8'd1;
                    end
                end
                SHIFT: begin
                    if (phase_q != 8'd0) begin
                        phase_q <= phase_q - 8'd1;
                    end else begin
                        phase_q <= PHASE_LOAD;
                        if (sclk_q) begin
                            sclk_q <= 1'b0;
                            // the last bit stays on SDATA through its low phase
                            if (bit_q != LAST_BIT) begin
                                sdata_q <= shift_q[17];
                                shift_q <= {shift_q[17:0], 1'b0};
                            end
                        end else if (bit_q == LAST_BIT) begin
                            state_q <= HOLD;
                        end else begin
                            sclk_q <= 1'b1;
                            bit_q  <= bit_q + 5'd1;
                        end
                    end
                end
                HOLD: begin
                    if (phase_q == 8'd0) begin
                        sle_n_q      <= 1'b1;
                        sdata_q      <= 1'b0;
                        xfer_count_q <= xfer_count_d;
                        phase_q      <= PHASE_LOAD;
                        state_q      <= GAP;
                    end else begin
                        phase_q <= phase_q - 8'd1;
                    end
                end
                GAP: begin
                    if (phase_q == 8'd0) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        phase_q <= phase_q - 8'd1;
                    end
                end
                default: state_q <= ARM;
            endcase
        end
    end

    assign adc_sclk   = sclk_q;
    assign adc_sdata  = sdata_q;
    assign adc_sle_n  = sle_n_q;
    assign busy       = busy_q;
    assign status_out = {busy_q, 15'b0, xfer_count_q};

endmodule

// File: tb/tb_adc_ctrl_serial.sv
module tb_adc_ctrl_serial;

    localparam int D = 2;

    logic        user_clk = 1'b0;
    logic        user_rst;
    logic [31:0] ctrl_word;
    logic        adc_sclk;
    logic        adc_sdata;
    logic        adc_sle_n;
    logic        busy;
    logic [31:0] status_out;

    adc_ctrl_serial #(.CLK_DIV(D)) dut (
        .user_clk   (user_clk),
        .user_rst   (user_rst),
        .ctrl_word  (ctrl_word),
        .adc_sclk   (adc_sclk),
        .adc_sdata  (adc_sdata),
        .adc_sle_n  (adc_sle_n),
        .busy       (busy),
        .status_out (status_out)
    );

    always #5 user_clk = ~user_clk;

    int cyc = 0;
    always @(posedge user_clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [18:0] bits;
        logic [15:0] cnt;
    } exp_t;

    exp_t sb_q[$];

    int total = 0;
    int bad   = 0;

    // monitor state
    logic        prev_sle   = 1'b1;
    logic        prev_sclk  = 1'b0;
    logic        prev_busy  = 1'b0;
    logic        prev_sdata = 1'b0;
    logic        in_frame   = 1'b0;
    logic [18:0] bits;
    int          n_frames   = 0;
    int          n_falls    = 0;
    int          pulses     = 0;
    int          low_cnt    = 0;
    int          fall_t     = 0;
    int          prev_fall_t = 0;

    logic [15:0] exp_cnt;
    int          f0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge user_clk);
            if (user_rst) begin
                in_frame = 1'b0;
            end else begin
                if (prev_sle && !adc_sle_n) begin
                    in_frame    = 1'b1;
                    prev_fall_t = fall_t;
                    fall_t      = cyc;
                    n_falls++;
                    low_cnt = 0;
                    pulses  = 0;
                    bits    = '0;
                end
                if (!adc_sle_n) begin
                    low_cnt++;
                    if (!prev_sclk && adc_sclk) begin
                        bits = {bits[17:0], adc_sdata};
                        pulses++;
                    end
                    if (prev_sclk && adc_sclk)
                        check_eq("sdata_hold", {31'b0, adc_sdata}, {31'b0, prev_sdata});
                end
                if (!prev_sle && adc_sle_n && in_frame) begin
                    n_frames++;
                    check_eq("pulses", pulses, 19);
                    check_eq("sle_low", low_cnt, 40 * D);
                    check_eq("sb_nonempty", {31'b0, sb_q.size() != 0}, 32'd1);
                    if (sb_q.size() != 0) begin
                        e = sb_q.pop_front();
                        check_eq("frame_bits", {13'b0, bits}, {13'b0, e.bits});
                        check_eq("status_at_end", status_out, {16'h8000, e.cnt});
                    end
                end
                if (prev_busy && !busy && in_frame) begin
                    check_eq("busy_fall", cyc - fall_t, 41 * D);
                    in_frame = 1'b0;
                end
            end
            prev_sle   = adc_sle_n;
            prev_sclk  = adc_sclk;
            prev_busy  = busy;
            prev_sdata = adc_sdata;
        end
    endtask

    task automatic drive(input logic [31:0] w);
        @(negedge user_clk);
        ctrl_word = w;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge user_clk);
    endtask

    task automatic wait_frames(input int n, input int budget);
        int t = 0;
        while (n_frames < n && t < budget) begin
            @(negedge user_clk);
            t++;
        end
        check_eq("timeout_frames", {31'b0, n_frames >= n}, 32'd1);
    endtask

    task automatic push(input logic [18:0] b, input logic [15:0] c);
        exp_t e;
        e.bits = b;
        e.cnt  = c;
        sb_q.push_back(e);
    endtask

    initial begin
        int t;
        ctrl_word = 32'h0;
        user_rst  = 1'b1;
        fork
            monitor();
        join_none
        idle(3);
        check_eq("rst_sclk",  {31'b0, adc_sclk},  32'd0);
        check_eq("rst_sdata", {31'b0, adc_sdata}, 32'd0);
        check_eq("rst_sle_n", {31'b0, adc_sle_n}, 32'd1);
        check_eq("rst_busy",  {31'b0, busy},      32'd0);
        check_eq("rst_status", status_out, 32'h0);
        user_rst = 1'b0;
        idle(5);
        exp_cnt = 16'd0;

        // basic frame and launch latency
        exp_cnt = exp_cnt + 16'd1;
        push(19'h1ABCD, exp_cnt);
        drive(32'h8001_ABCD);
        idle(1);
        check_eq("lat_edge1_sle_n", {31'b0, adc_sle_n}, 32'd1);
        idle(1);
        check_eq("lat_edge2_sle_n", {31'b0, adc_sle_n}, 32'd0);
        check_eq("lat_edge2_busy",  {31'b0, busy},      32'd1);
        wait_frames(1, 200);
        idle(10);
        check_eq("basic_status", status_out, 32'h0000_0001);

        // rewrites without a toggle
        f0 = n_falls;
        drive(32'h8001_ABCD);
        idle(100);
        drive(32'h8002_1234);
        idle(200);
        check_eq("notog_falls", n_falls, f0);
        check_eq("notog_status", status_out, 32'h0000_0001);

        // toggle while busy: back-to-back frames
        exp_cnt = exp_cnt + 16'd1;
        push(19'h300FF, exp_cnt);
        exp_cnt = exp_cnt + 16'd1;
        push(19'h50F0F, exp_cnt);
        drive(32'h0003_00FF);
        idle(10);
        drive(32'h8005_0F0F);
        wait_frames(3, 500);
        check_eq("b2b_spacing", fall_t - prev_fall_t, 41 * D + 1);
        idle(10);
        check_eq("b2b_status", status_out, 32'h0000_0003);

        // two toggles inside one frame cancel
        f0 = n_falls;
        exp_cnt = exp_cnt + 16'd1;
        push(19'h41111, exp_cnt);
        drive(32'h0004_1111);
        idle(20);
        drive(32'h8004_2222);
        idle(10);
        drive(32'h0004_3333);
        wait_frames(4, 300);
        idle(300);
        check_eq("dbl_falls", n_falls, f0 + 1);
        check_eq("dbl_status", status_out, 32'h0000_0004);

        // reset at bit 7 of a frame
        f0 = n_falls;
        drive(32'h8006_5555);
        t = 0;
        while (!(n_falls > f0 && pulses >= 8) && t < 300) begin
            @(negedge user_clk);
            t++;
        end
        check_eq("bit7_reached", {31'b0, n_falls > f0 && pulses >= 8}, 32'd1);
        #2;
        user_rst = 1'b1;
        #1;
        check_eq("midrst_sle_n", {31'b0, adc_sle_n}, 32'd1);
        check_eq("midrst_sclk",  {31'b0, adc_sclk},  32'd0);
        check_eq("midrst_busy",  {31'b0, busy},      32'd0);
        check_eq("midrst_status", status_out, 32'h0);
        exp_cnt = 16'd0;
        idle(3);
        user_rst = 1'b0;
        idle(300);
        check_eq("midrst_no_resend", n_falls, f0 + 1);
        check_eq("midrst_status_after", status_out, 32'h0);

        // counter wrap
        @(negedge user_clk);
        force dut.xfer_count_q = 16'hFFFF;
        @(negedge user_clk);
        release dut.xfer_count_q;
        @(negedge user_clk);
        check_eq("wrap_preload", status_out, 32'h0000_FFFF);
        exp_cnt = 16'hFFFF + 16'd1;
        push(19'h7000F, exp_cnt);
        drive(32'h0007_000F);
        wait_frames(5, 300);
        check_eq("wrap_busy_in_gap", {31'b0, busy}, 32'd1);
        idle(20);
        check_eq("wrap_status", status_out, 32'h0000_0000);

        check_eq("sb_drained", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
